// File: rtl/statelink_decouple_ctrl.sv
// Initiator side of the StateLink decouple/stop handshake.
// Drives decouple into the registered AXIS StateLink wrapper, waits for every
// per-channel stop_ack, holds the frozen state until the host asks to resume,
// then waits for all acks to clear. Measures stop latency and flags channels
// that fail to acknowledge within TIMEOUT_CYCLES.
//
// Ports:
//   axis_clk_0    clock (AXIS stream domain)
//   axis_rst_n_0  asynchronous active-low reset
//   stop_req      host level request to decouple
//   resume_req    host level request to release
//   err_clr       clears sticky timeout_err
//   stop_ack      per-channel acknowledge from the wrapper
//   decouple      decouple request to the wrapper
//   stopped       all channels acknowledged, state frozen
//   busy          handshake in progress (decouple or release phase)
//   timeout_err   sticky handshake timeout flag
//   err_ch        channels at fault when the last timeout fired
//   ack_latency   cycles from decouple rise to all-ack, last successful stop
module statelink_decouple_ctrl #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 axis_clk_0,
    input  logic                 axis_rst_n_0,
    input  logic                 stop_req,
    input  logic                 resume_req,
    input  logic                 err_clr,
    input  logic [NUM_CH-1:0]    stop_ack,
    output logic                 decouple,
    output logic                 stopped,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [NUM_CH-1:0]    err_ch,
    output logic [CNT_WIDTH-1:0] ack_latency
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DECOUPLE = 3'd1;
    localparam logic [2:0] ST_STOPPED  = 3'd2;
    localparam logic [2:0] ST_RELEASE  = 3'd3;
    localparam logic [2:0] ST_ERROR    = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic [CNT_WIDTH-1:0] wait_cnt_nxt;
    logic [CNT_WIDTH-1:0] ack_latency_nxt;
    logic [NUM_CH-1:0]    err_ch_nxt;
    logic                 decouple_nxt;
    logic                 stopped_nxt;
    logic                 busy_nxt;
    logic                 timeout_err_nxt;
    logic                 timeout_set;
    logic                 all_ack;
    logic                 none_ack;
    logic                 cnt_expired;

    assign all_ack     = &stop_ack;
    assign none_ack    = ~|stop_ack;
    assign cnt_expired = (wait_cnt == CNT_LAST);

    // State and registered outputs; reset drops decouple without waiting for a clock.
    always_ff @(posedge axis_clk_0 or negedge axis_rst_n_0) begin
        if (!axis_rst_n_0) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            decouple    <= 1'b0;
            stopped     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            err_ch      <= '0;
            ack_latency <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            decouple    <= decouple_nxt;
            stopped     <= stopped_nxt;
            busy        <= busy_nxt;
            timeout_err <= timeout_err_nxt;
            err_ch      <= err_ch_nxt;
            ack_latency <= ack_latency_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        ack_latency_nxt = ack_latency;
        err_ch_nxt      = err_ch;
        decouple_nxt    = decouple;
        timeout_set     = 1'b0;

        case (state)
            ST_IDLE: begin
                decouple_nxt = 1'b0;
                if (stop_req) begin
                    state_nxt    = ST_DECOUPLE;
                    wait_cnt_nxt = '0;
                    decouple_nxt = 1'b1;
                end
            end

            ST_DECOUPLE: begin
                // decouple stays high whether we stop or time out.
                decouple_nxt = 1'b1;
                if (all_ack) begin
                    state_nxt       = ST_STOPPED;
                    ack_latency_nxt = wait_cnt + CNT_ONE;
                end else if (cnt_expired) begin
                    state_nxt   = ST_ERROR;
                    timeout_set = 1'b1;
                    err_ch_nxt  = ~stop_ack;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_ONE;
                end
            end

            ST_STOPPED: begin
                decouple_nxt = 1'b1;
                if (resume_req) begin
                    state_nxt    = ST_RELEASE;
                    wait_cnt_nxt = '0;
                    decouple_nxt = 1'b0;
                end
            end

            ST_RELEASE: begin
                decouple_nxt = 1'b0;
                if (none_ack) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_expired) begin
                    state_nxt   = ST_ERROR;
                    timeout_set = 1'b1;
                    err_ch_nxt  = stop_ack;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_ONE;
                end
            end

            ST_ERROR: begin
                // decouple keeps whatever the failed phase left it at.
                if (resume_req) begin
                    state_nxt    = ST_RELEASE;
                    wait_cnt_nxt = '0;
                    decouple_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt    = ST_IDLE;
                wait_cnt_nxt = '0;
                decouple_nxt = 1'b0;
            end
        endcase

        // A timeout on the same edge as err_clr keeps the flag set.
        if (timeout_set) begin
            timeout_err_nxt = 1'b1;
        end else if (err_clr) begin
            timeout_err_nxt = 1'b0;
        end else begin
            timeout_err_nxt = timeout_err;
        end

        stopped_nxt = (state_nxt == ST_STOPPED);
        busy_nxt    = (state_nxt == ST_DECOUPLE) || (state_nxt == ST_RELEASE);
    end

endmodule

// File: tb/tb_statelink_decouple_ctrl.sv
// Directed bench for statelink_decouple_ctrl (NUM_CH=2, TIMEOUT_CYCLES=16).
module tb_statelink_decouple_ctrl;

    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CW      = 8;

    logic          clk;
    logic          rst_n;
    logic          stop_req;
    logic          resume_req;
    logic          err_clr;
    logic [1:0]    stop_ack;
    logic          decouple;
    logic          stopped;
    logic          busy;
    logic          timeout_err;
    logic [1:0]    err_ch;
    logic [CW-1:0] ack_latency;

    typedef struct {
        string         tag;
        logic          dec;
        logic          stp;
        logic          bsy;
        logic          terr;
        logic [1:0]    ech;
        logic [CW-1:0] lat;
    } exp_t;

    exp_t sb[$];
    int   tests_run;
    int   tests_failed;

    statelink_decouple_ctrl #(
        .NUM_CH        (NUM_CH),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_WIDTH     (CW)
    ) dut (
        .axis_clk_0  (clk),
        .axis_rst_n_0(rst_n),
        .stop_req    (stop_req),
        .resume_req  (resume_req),
        .err_clr     (err_clr),
        .stop_ack    (stop_ack),
        .decouple    (decouple),
        .stopped     (stopped),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_ch      (err_ch),
        .ack_latency (ack_latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic dec, input logic stp, input logic bsy,
                        input logic terr, input logic [1:0] ech, input logic [CW-1:0] lat);
        exp_t e;
        e.tag = tag; e.dec = dec; e.stp = stp; e.bsy = bsy;
        e.terr = terr; e.ech = ech; e.lat = lat;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic check_pop();
        exp_t e;
        tests_run++;
        assert (sb.size() != 0) else begin
            tests_failed++;
            $error("FAIL scoreboard_empty observed=0 expected=entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            tests_run += 6;
            assert (decouple === e.dec) else begin
                tests_failed++;
                $error("FAIL %s.decouple observed=%b expected=%b", e.tag, decouple, e.dec);
            end
            assert (stopped === e.stp) else begin
                tests_failed++;
                $error("FAIL %s.stopped observed=%b expected=%b", e.tag, stopped, e.stp);
            end
            assert (busy === e.bsy) else begin
                tests_failed++;
                $error("FAIL %s.busy observed=%b expected=%b", e.tag, busy, e.bsy);
            end
            assert (timeout_err === e.terr) else begin
                tests_failed++;
                $error("FAIL %s.timeout_err observed=%b expected=%b", e.tag, timeout_err, e.terr);
            end
            assert (err_ch === e.ech) else begin
                tests_failed++;
                $error("FAIL %s.err_ch observed=%b expected=%b", e.tag, err_ch, e.ech);
            end
            assert (ack_latency === e.lat) else begin
                tests_failed++;
                $error("FAIL %s.ack_latency observed=%0d expected=%0d", e.tag, ack_latency, e.lat);
            end
        end
    endtask

    // One clock edge, then compare just after it.
    task automatic step();
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n      = 1'b0;
        stop_req   = 1'b0;
        resume_req = 1'b0;
        err_clr    = 1'b0;
        stop_ack   = 2'b00;

        // Reset state
        #12;
        push("reset", 0, 0, 0, 0, 2'b00, 0);
        check_pop();
        rst_n = 1'b1;

        // Normal stop/resume, ack at k=3
        @(posedge clk); #1;
        stop_req = 1'b1;
        push("n_stop0", 1, 0, 1, 0, 2'b00, 0); step();
        stop_req = 1'b0;
        push("n_wait1", 1, 0, 1, 0, 2'b00, 0); step();
        push("n_wait2", 1, 0, 1, 0, 2'b00, 0); step();
        stop_ack = 2'b11;
        push("n_stopped", 1, 1, 0, 0, 2'b00, 3); step();
        resume_req = 1'b1;
        push("n_release", 0, 0, 1, 0, 2'b00, 3); step();
        resume_req = 1'b0;
        push("n_rel_wait", 0, 0, 1, 0, 2'b00, 3); step();
        stop_ack = 2'b00;
        push("n_idle", 0, 0, 0, 0, 2'b00, 3); step();

        // Partial ack timeout
        stop_ack = 2'b01;
        stop_req = 1'b1;
        push("p_stop0", 1, 0, 1, 0, 2'b00, 3); step();
        stop_req = 1'b0;
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            push("p_wait", 1, 0, 1, 0, 2'b00, 3); step();
        end
        push("p_timeout", 1, 0, 0, 1, 2'b10, 3); step();
        // Late acks and stop_req do not leave ERROR
        stop_ack = 2'b11;
        stop_req = 1'b1;
        push("p_late_ack", 1, 0, 0, 1, 2'b10, 3); step();
        stop_req = 1'b0;

        // Recovery from ERROR
        resume_req = 1'b1;
        push("r_release", 0, 0, 1, 1, 2'b10, 3); step();
        resume_req = 1'b0;
        stop_ack = 2'b00;
        push("r_idle", 0, 0, 0, 1, 2'b10, 3); step();
        err_clr = 1'b1;
        push("r_err_clr", 0, 0, 0, 0, 2'b10, 3); step();
        err_clr = 1'b0;
        stop_req = 1'b1;
        push("r_stop0", 1, 0, 1, 0, 2'b10, 3); step();
        stop_req = 1'b0;
        stop_ack = 2'b11;
        push("r_stopped_k1", 1, 1, 0, 0, 2'b10, 1); step();

        // Release timeout with acks stuck high
        resume_req = 1'b1;
        push("t_release0", 0, 0, 1, 0, 2'b10, 1); step();
        resume_req = 1'b0;
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            push("t_wait", 0, 0, 1, 0, 2'b10, 1); step();
        end
        push("t_timeout", 0, 0, 0, 1, 2'b11, 1); step();
        resume_req = 1'b1;
        stop_ack = 2'b00;
        push("t_rel_again", 0, 0, 1, 1, 2'b11, 1); step();
        resume_req = 1'b0;
        push("t_idle", 0, 0, 0, 1, 2'b11, 1); step();

        // resume_req alone in IDLE is ignored
        resume_req = 1'b1;
        push("i_resume_idle", 0, 0, 0, 1, 2'b11, 1); step();

        // Both requests: IDLE honours stop, STOPPED honours resume
        stop_req = 1'b1;
        push("b_idle_both", 1, 0, 1, 1, 2'b11, 1); step();
        stop_ack = 2'b11;
        push("b_stopped", 1, 1, 0, 1, 2'b11, 1); step();
        push("b_stopped_both", 0, 0, 1, 1, 2'b11, 1); step();
        resume_req = 1'b0;
        stop_ack = 2'b00;
        push("b_idle", 0, 0, 0, 1, 2'b11, 1); step();
        // stop_req still high restarts the handshake
        push("b_restart", 1, 0, 1, 1, 2'b11, 1); step();
        stop_req = 1'b0;

        // Coincident err_clr and timeout: set wins
        err_clr = 1'b1;
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            push("c_wait", 1, 0, 1, 0, 2'b11, 1); step();
            err_clr = 1'b0;
        end
        err_clr = 1'b1;
        push("c_set_wins", 1, 0, 0, 1, 2'b11, 1); step();
        push("c_clear", 1, 0, 0, 0, 2'b11, 1); step();
        err_clr = 1'b0;
        resume_req = 1'b1;
        push("c_release", 0, 0, 1, 0, 2'b11, 1); step();
        resume_req = 1'b0;
        push("c_idle", 0, 0, 0, 0, 2'b11, 1); step();

        // Async reset mid-DECOUPLE
        stop_req = 1'b1;
        push("a_stop0", 1, 0, 1, 0, 2'b11, 1); step();
        stop_req = 1'b0;
        push("a_wait", 1, 0, 1, 0, 2'b11, 1); step();
        #2;
        rst_n = 1'b0;
        #1;
        push("a_async_rst", 0, 0, 0, 0, 2'b00, 0);
        check_pop();
        rst_n = 1'b1;
        stop_req = 1'b1;
        push("a_restart", 1, 0, 1, 0, 2'b00, 0); step();
        stop_req = 1'b0;
        push("a_wait1", 1, 0, 1, 0, 2'b00, 0); step();
        stop_ack = 2'b11;
        push("a_stopped_k2", 1, 1, 0, 0, 2'b00, 2); step();

        // Every pushed expectation must have been consumed
        tests_run++;
        assert (sb.size() == 0) else begin
            tests_failed++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
